quick_spi_slave: RTL and testbench

SPI slave endpoint that sits directly downstream of the quick_spi master on the bus. It oversamples sclk/ss_n/mosi in the system clock domain, deserialises LSB-first elements of configurable width to a parallel rx stream, and serialises tx elements onto miso. It is used as the loopback and peripheral model for master bring-up, and as the synthesizable slave core for FPGA-to-FPGA links.

---
 rtl/quick_spi_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_quick_spi_slave.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_slave.sv
// -----------------------------------------------------------------------------
// quick_spi_slave
//
// SPI slave endpoint. sclk, ss_n and mosi are oversampled in the clk domain
// (clk must run at least 8x the sclk frequency). Elements of 1..MAX_ELEMENT_SIZE
// bits are received LSB-first into rx_data and transmitted LSB-first on miso
// from a one-entry tx holding register.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   sclk, ss_n, mosi   SPI bus inputs (asynchronous to clk)
//   miso, miso_oe      SPI data out and its pad enable (high only in ACTIVE)
//   element_size       bits per element, latched at frame start (0/>max = max)
//   rx_data, rx_valid  received element and its one-cycle strobe
//   tx_data, tx_valid  element to transmit, accepted when tx_ready is high
//   tx_ready           holding register empty
//   tx_underrun        pulse: element started with the holding register empty
//   frame_active       high while a frame is in progress
//   frame_error        pulse: ss_n deasserted in the middle of an element
// -----------------------------------------------------------------------------
module quick_spi_slave #(
    parameter int CPOL             = 0,
    parameter int CPHA             = 0,
    parameter int MAX_ELEMENT_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sclk,
    input  logic                        ss_n,
    input  logic                        mosi,
    output logic                        miso,
    output logic                        miso_oe,
    input  logic [4:0]                  element_size,
    output logic [MAX_ELEMENT_SIZE-1:0] rx_data,
    output logic                        rx_valid,
    input  logic [MAX_ELEMENT_SIZE-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_underrun,
    output logic                        frame_active,
    output logic                        frame_error
);

    localparam int   W         = MAX_ELEMENT_SIZE;
    localparam int   CW        = $clog2(W + 1);
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    function automatic logic [CW-1:0] eff_size(input logic [4:0] es);
        if (es == 5'd0 || int'(es) > W) begin
            return CW'(W);
        end
        return CW'(es);
    endfunction

    // Synchronisers. ss_n resets to 0 so that WAIT_IDLE only leaves once the
    // real pin has been seen high after reset.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta_q <= SCLK_IDLE;
            sclk_sync_q <= SCLK_IDLE;
            sclk_prev_q <= SCLK_IDLE;
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ss_meta_q   <= ss_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;

    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign ss_fall     = ~ss_sync_q & ss_prev_q;
    assign ss_rise     = ss_sync_q & ~ss_prev_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   size_q, size_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [W-1:0]    rx_shift_q, rx_shift_d;
    logic [W-1:0]    tx_shift_q, tx_shift_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            underrun_q, underrun_d;
    logic            ferr_q, ferr_d;
    logic            first_shift_q, first_shift_d;

    logic [W-1:0]    size_mask;
    logic [W-1:0]    assembled;
    logic [CW-1:0]   bit_cnt_nx;
    logic            consume;

    // Shifting by the full width yields 0, so size==W gives an all-ones mask.
    assign size_mask = ~({W{1'b1}} << size_q);

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        bit_cnt_d     = bit_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        underrun_d    = 1'b0;
        ferr_d        = 1'b0;
        first_shift_d = first_shift_q;
        assembled     = rx_shift_q;
        bit_cnt_nx    = bit_cnt_q;
        consume       = 1'b0;

        // Loads are only accepted while empty, so they never collide with a
        // consume of a full register.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (ss_sync_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    size_d        = eff_size(element_size);
                    bit_cnt_d     = '0;
                    tx_cnt_d      = '0;
                    rx_shift_d    = '0;
                    first_shift_d = 1'b1;
                    consume       = 1'b1;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    assembled = rx_shift_q | (W'(mosi_sync_q) << bit_cnt_q);
                    if (bit_cnt_q == size_q - 1'b1) begin
                        rx_data_d  = assembled & size_mask;
                        rx_valid_d = 1'b1;
                        rx_shift_d = '0;
                        bit_cnt_nx = '0;
                    end else begin
                        rx_shift_d = assembled;
                        bit_cnt_nx = bit_cnt_q + 1'b1;
                    end
                    bit_cnt_d = bit_cnt_nx;
                end
                // A sample landing in the same cycle as ss_n rising is
                // completed first, so only a genuinely partial element errors.
                if (ss_rise) begin
                    state_d    = IDLE;
                    ferr_d     = (bit_cnt_nx != '0);
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (shift_edge) begin
                    if (CPHA != 0 && first_shift_q) begin
                        // Bit 0 is already on miso from frame start.
                        first_shift_d = 1'b0;
                    end else if (tx_cnt_q == size_q - 1'b1) begin
                        tx_cnt_d = '0;
                        consume  = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_cnt_d   = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (consume) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_IDLE;
            size_q        <= CW'(W);
            bit_cnt_q     <= '0;
            tx_cnt_q      <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            underrun_q    <= 1'b0;
            ferr_q        <= 1'b0;
            first_shift_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            underrun_q    <= underrun_d;
            ferr_q        <= ferr_d;
            first_shift_q <= first_shift_d;
        end
    end

    assign frame_active = (state_q == ACTIVE);
    assign miso_oe      = frame_active;
    assign miso         = frame_active & tx_shift_q[0];
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_ready     = ~hold_full_q;
    assign tx_underrun  = underrun_q;
    assign frame_error  = ferr_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
module tb_quick_spi_slave;

    localparam int H = 5;  // clk cycles per sclk half period

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // Instance 0: CPOL=0, CPHA=0
    logic        sclk0 = 1'b0, ss_n0 = 1'b1, mosi0 = 1'b0;
    logic        miso0, miso_oe0;
    logic [4:0]  es0 = 5'd8;
    logic [15:0] rx_data0;
    logic        rx_valid0;
    logic [15:0] tx_data0 = '0;
    logic        tx_valid0 = 1'b0;
    logic        tx_ready0, tx_underrun0, frame_active0, frame_error0;

    // Instance 1: CPOL=1, CPHA=1
    logic        sclk1 = 1'b1, ss_n1 = 1'b1, mosi1 = 1'b0;
    logic        miso1, miso_oe1;
    logic [4:0]  es1 = 5'd9;
    logic [15:0] rx_data1;
    logic        rx_valid1;
    logic [15:0] tx_data1 = '0;
    logic        tx_valid1 = 1'b0;
    logic        tx_ready1, tx_underrun1, frame_active1, frame_error1;

    always #5 clk = ~clk;

    quick_spi_slave #(.CPOL(0), .CPHA(0), .MAX_ELEMENT_SIZE(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk0), .ss_n(ss_n0), .mosi(mosi0),
        .miso(miso0), .miso_oe(miso_oe0), .element_size(es0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_underrun(tx_underrun0),
        .frame_active(frame_active0), .frame_error(frame_error0)
    );

    quick_spi_slave #(.CPOL(1), .CPHA(1), .MAX_ELEMENT_SIZE(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk1), .ss_n(ss_n1), .mosi(mosi1),
        .miso(miso1), .miso_oe(miso_oe1), .element_size(es1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_underrun(tx_underrun1),
        .frame_active(frame_active1), .frame_error(frame_error1)
    );

    // Pulse monitors
    logic [15:0] rx_log0[$];
    int          unr0 = 0, ferr0 = 0;
    int          rx_cnt1 = 0, ferr1 = 0, unr1 = 0;
    logic [15:0] rx_last1 = '0;

    always @(negedge clk) begin
        if (rx_valid0) rx_log0.push_back(rx_data0);
        if (tx_underrun0) unr0++;
        if (frame_error0) ferr0++;
        if (rx_valid1) begin
            rx_cnt1++;
            rx_last1 = rx_data1;
        end
        if (frame_error1) ferr1++;
        if (tx_underrun1) unr1++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic load0(input logic [15:0] d);
        int t = 0;
        while (!tx_ready0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait0", 32'(t < 200), 32'd1);
        tx_data0  = d;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
    endtask

    task automatic m0_begin();
        ss_n0 = 1'b0;
        wait_h();
    endtask

    task automatic m0_bit(input logic b, output logic seen);
        mosi0 = b;
        wait_h();
        sclk0 = 1'b1;
        seen  = miso0;
        wait_h();
        sclk0 = 1'b0;
    endtask

    task automatic m0_word(input logic [15:0] w, input int n, output logic [15:0] got);
        logic s;
        got = '0;
        for (int i = 0; i < n; i++) begin
            m0_bit(w[i], s);
            got[i] = s;
        end
    endtask

    task automatic m0_end();
        wait_h();
        ss_n0 = 1'b1;
        wait_h();
        wait_h();
    endtask

    function automatic logic [15:0] rx_at(input int idx);
        if (rx_log0.size() > idx) return rx_log0[idx];
        return 16'hxxxx;
    endfunction

    typedef struct {
        logic [4:0]  size;
        logic [15:0] mosi_w;
        logic [15:0] tx_w;
        logic        preload;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
        int          nbits;
        int          exp_unr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] got, got2;
        logic        s;
        int          base, ub, fb;

        vecs[0] = '{5'd8,  16'h001A, 16'h00A5, 1'b1, 16'h001A, 16'h00A5, 8,  1};
        vecs[1] = '{5'd4,  16'h0005, 16'h000C, 1'b1, 16'h0005, 16'h000C, 4,  1};
        vecs[2] = '{5'd16, 16'hBEEF, 16'h1234, 1'b1, 16'hBEEF, 16'h1234, 16, 1};
        vecs[3] = '{5'd0,  16'h8001, 16'hF00F, 1'b1, 16'h8001, 16'hF00F, 16, 1};
        vecs[4] = '{5'd1,  16'h0001, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1,  1};
        vecs[5] = '{5'd20, 16'h7FFE, 16'h0000, 1'b0, 16'h7FFE, 16'h0000, 16, 2};
        vecs[6] = '{5'd3,  16'h0006, 16'hFFFF, 1'b1, 16'h0006, 16'h0007, 3,  1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_miso_oe", 32'(miso_oe0), 0);
        chk("rst_miso", 32'(miso0), 0);
        chk("rst_tx_ready", 32'(tx_ready0), 1);
        chk("rst_rx_valid", 32'(rx_valid0), 0);
        chk("rst_rx_data", 32'(rx_data0), 0);
        chk("rst_frame_active", 32'(frame_active0), 0);
        chk("rst_underrun", 32'(tx_underrun0), 0);
        chk("rst_frame_error", 32'(frame_error0), 0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // Table-driven single-element frames on the CPOL=0/CPHA=0 slave
        for (int v = 0; v < 7; v++) begin
            es0 = vecs[v].size;
            if (vecs[v].preload) load0(vecs[v].tx_w);
            base = rx_log0.size();
            ub   = unr0;
            fb   = ferr0;
            m0_begin();
            chk($sformatf("v%0d_miso_oe", v), 32'(miso_oe0), 1);
            m0_word(vecs[v].mosi_w, vecs[v].nbits, got);
            m0_end();
            chk($sformatf("v%0d_rx_count", v), 32'(rx_log0.size() - base), 1);
            chk($sformatf("v%0d_rx_data", v), 32'(rx_at(base)), 32'(vecs[v].exp_rx));
            chk($sformatf("v%0d_miso_bits", v), 32'(got), 32'(vecs[v].exp_miso));
            chk($sformatf("v%0d_frame_error", v), 32'(ferr0 - fb), 0);
            chk($sformatf("v%0d_underrun", v), 32'(unr0 - ub), 32'(vecs[v].exp_unr));
        end
        chk("idle_miso_oe", 32'(miso_oe0), 0);

        // Two elements in one frame, second tx element loaded mid-frame
        es0 = 5'd8;
        load0(16'h00A5);
        base = rx_log0.size();
        fb   = ferr0;
        m0_begin();
        load0(16'h003C);
        m0_word(16'h001A, 8, got);
        m0_word(16'h006A, 8, got2);
        m0_end();
        chk("two_rx_count", 32'(rx_log0.size() - base), 2);
        chk("two_rx_first", 32'(rx_at(base)), 32'h1A);
        chk("two_rx_second", 32'(rx_at(base + 1)), 32'h6A);
        chk("two_miso_first", 32'(got), 32'hA5);
        chk("two_miso_second", 32'(got2), 32'h3C);
        chk("two_frame_error", 32'(ferr0 - fb), 0);

        // Underrun at frame start
        base = rx_log0.size();
        ub   = unr0;
        chk("unr_ready_before", 32'(tx_ready0), 1);
        m0_begin();
        load0(16'h0077);
        chk("unr_ready_after_load", 32'(tx_ready0), 0);
        m0_word(16'h001A, 8, got);
        m0_end();
        chk("unr_pulses", 32'(unr0 - ub), 1);
        chk("unr_miso_zero", 32'(got), 0);
        chk("unr_rx_data", 32'(rx_at(base)), 32'h1A);

        // ss_n raised after 5 of 8 bits, then a clean frame
        base = rx_log0.size();
        fb   = ferr0;
        m0_begin();
        m0_word(16'h001A, 5, got);
        m0_end();
        chk("ferr_pulse", 32'(ferr0 - fb), 1);
        chk("ferr_no_rx", 32'(rx_log0.size() - base), 0);
        fb = ferr0;
        m0_begin();
        m0_word(16'h001A, 8, got);
        m0_end();
        chk("after_ferr_rx_count", 32'(rx_log0.size() - base), 1);
        chk("after_ferr_rx_data", 32'(rx_at(base)), 32'h1A);
        chk("after_ferr_no_error", 32'(ferr0 - fb), 0);

        // Final sample edge and ss_n rise arrive together
        base = rx_log0.size();
        fb   = ferr0;
        m0_begin();
        m0_word(16'h006A, 7, got);
        mosi0 = 1'b0;
        wait_h();
        sclk0 = 1'b1;
        ss_n0 = 1'b1;
        wait_h();
        sclk0 = 1'b0;
        wait_h();
        wait_h();
        chk("simul_rx_count", 32'(rx_log0.size() - base), 1);
        chk("simul_rx_data", 32'(rx_at(base)), 32'h6A);
        chk("simul_no_error", 32'(ferr0 - fb), 0);

        // Reset asserted mid-frame, released while ss_n is still low
        m0_begin();
        load0(16'h0055);
        chk("pre_rst_ready", 32'(tx_ready0), 0);
        m0_word(16'h0007, 3, got);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_miso_oe", 32'(miso_oe0), 0);
        chk("mid_rst_miso", 32'(miso0), 0);
        chk("mid_rst_frame_active", 32'(frame_active0), 0);
        chk("mid_rst_tx_ready", 32'(tx_ready0), 1);
        chk("mid_rst_rx_data", 32'(rx_data0), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        base = rx_log0.size();
        m0_word(16'h00FF, 8, got);
        chk("post_rst_ignored_rx", 32'(rx_log0.size() - base), 0);
        chk("post_rst_inactive", 32'(frame_active0), 0);
        m0_end();
        m0_begin();
        m0_word(16'h001A, 8, got);
        m0_end();
        chk("post_rst_rx_count", 32'(rx_log0.size() - base), 1);
        chk("post_rst_rx_data", 32'(rx_at(base)), 32'h1A);

        // CPOL=1/CPHA=1, 9-bit element
        begin
            int t = 0;
            logic [15:0] w1 = 16'h0155;
            logic [15:0] g1 = '0;
            logic        first_lead = 1'b0;
            int rb = rx_cnt1, f1 = ferr1, u1 = unr1;
            while (!tx_ready1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("tx_ready_wait1", 32'(t < 200), 32'd1);
            tx_data1  = 16'h01C3;
            tx_valid1 = 1'b1;
            @(negedge clk);
            tx_valid1 = 1'b0;
            es1   = 5'd9;
            ss_n1 = 1'b0;
            wait_h();
            for (int i = 0; i < 9; i++) begin
                sclk1 = 1'b0;
                mosi1 = w1[i];
                if (i == 0) first_lead = miso1;
                wait_h();
                sclk1 = 1'b1;
                g1[i] = miso1;
                wait_h();
            end
            wait_h();
            ss_n1 = 1'b1;
            wait_h();
            wait_h();
            chk("c11_first_lead_miso", 32'(first_lead), 1);
            chk("c11_miso_bits", 32'(g1), 32'h01C3);
            chk("c11_rx_count", 32'(rx_cnt1 - rb), 1);
            chk("c11_rx_data", 32'(rx_last1), 32'h0155);
            chk("c11_rx_upper_zero", 32'(rx_data1[15:9]), 0);
            chk("c11_frame_error", 32'(ferr1 - f1), 0);
            chk("c11_underrun", 32'(unr1 - u1), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
